// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/PC stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        TRAP   = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        MISALIGNED   = 2'd1,
        OUT_OF_RANGE = 2'd2
    } trap_cause_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC selection with alignment and ROM-range checks.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] next_pc,
    output logic        misaligned,
    output logic        out_of_range
);

    logic [31:0] seq_pc;

    assign seq_pc = pc + 32'(INSTR_BYTES);

    // Range uses the full 32-bit value so aliasing above the ROM is caught.
    always_comb begin
        next_pc      = seq_pc;
        misaligned   = 1'b0;
        out_of_range = (seq_pc >> ADDR_WIDTH) != '0;
        if (redirect) begin
            next_pc      = target;
            misaligned   = target[1:0] != 2'b00;
            out_of_range = !misaligned && ((target >> ADDR_WIDTH) != '0);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, fetch FSM and cycle/instret counters for the single-cycle RV32 core.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_valid_i,
    input  logic [31:0]           redirect_target_i,
    input  logic                  halt_i,
    output logic [ADDR_WIDTH-1:0] read_address_o,
    output logic [31:0]           pc_o,
    output logic [31:0]           pc_plus4_o,
    output logic                  instr_valid_o,
    output logic                  halted_o,
    output logic                  trap_o,
    output logic [1:0]            trap_cause_o,
    output logic [31:0]           cycle_count_o,
    output logic [31:0]           instret_o
);

    fetch_state_t state, state_next;
    trap_cause_t  cause, cause_next;
    logic [31:0]  pc, next_pc, cycle_count, instret;
    logic         misaligned, out_of_range;
    logic         pc_load, retire, cycle_inc;

    next_pc_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_pc_calc (
        .pc           (pc),
        .redirect     (redirect_valid_i),
        .target       (redirect_target_i),
        .next_pc      (next_pc),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cause_next = cause;
        pc_load    = 1'b0;
        retire     = 1'b0;
        cycle_inc  = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (!stall_i) begin
                    cycle_inc = 1'b1;
                    if (halt_i) begin
                        state_next = HALTED;
                        retire     = 1'b1;
                    end else if (misaligned) begin
                        state_next = TRAP;
                        cause_next = MISALIGNED;
                    end else if (out_of_range) begin
                        state_next = TRAP;
                        cause_next = OUT_OF_RANGE;
                    end else begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                    end
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            cycle_count <= '0;
            instret     <= '0;
            cause       <= NONE;
        end else begin
            if (pc_load)   pc          <= next_pc;
            if (retire)    instret     <= instret + 32'd1;
            if (cycle_inc) cycle_count <= cycle_count + 32'd1;
            cause <= cause_next;
        end
    end

    always_comb begin
        instr_valid_o = state == RUN;
        halted_o      = state == HALTED;
        trap_o        = state == TRAP;
        trap_cause_o  = cause;
    end

    assign read_address_o = pc[ADDR_WIDTH-1:0];
    assign pc_o           = pc;
    assign pc_plus4_o     = pc + 32'(INSTR_BYTES);
    assign cycle_count_o  = cycle_count;
    assign instret_o      = instret;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed table, corner sequences, random vs model.
module tb_fetch_pc_unit;

    localparam int unsigned AW = 10;
    localparam longint LIMIT = 64'd1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall_i = 1'b0;
    logic          redirect_valid_i = 1'b0;
    logic [31:0]   redirect_target_i = '0;
    logic          halt_i = 1'b0;
    logic [AW-1:0] read_address_o;
    logic [31:0]   pc_o, pc_plus4_o, cycle_count_o, instret_o;
    logic          instr_valid_o, halted_o, trap_o;
    logic [1:0]    trap_cause_o;

    int tests = 0;
    int fails = 0;

    fetch_pc_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .halt_i            (halt_i),
        .read_address_o    (read_address_o),
        .pc_o              (pc_o),
        .pc_plus4_o        (pc_plus4_o),
        .instr_valid_o     (instr_valid_o),
        .halted_o          (halted_o),
        .trap_o            (trap_o),
        .trap_cause_o      (trap_cause_o),
        .cycle_count_o     (cycle_count_o),
        .instret_o         (instret_o)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 boot, 1 run, 2 halted, 3 trapped.
    int      m_mode;
    longint  m_pc, m_cyc, m_inst;
    int      m_cause;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_cyc = 0; m_inst = 0; m_cause = 0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic h, input logic [31:0] t);
        longint tl = longint'(t);
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && !s) begin
            m_cyc = (m_cyc + 1) % (64'd1 << 32);
            if (h) begin
                m_mode = 2; m_inst = (m_inst + 1) % (64'd1 << 32);
            end else if (r && (tl % 4) != 0) begin
                m_mode = 3; m_cause = 1;
            end else if (r && tl >= LIMIT) begin
                m_mode = 3; m_cause = 2;
            end else if (r) begin
                m_pc = tl; m_inst = (m_inst + 1) % (64'd1 << 32);
            end else if (m_pc + 4 >= LIMIT) begin
                m_mode = 3; m_cause = 2;
            end else begin
                m_pc = m_pc + 4; m_inst = (m_inst + 1) % (64'd1 << 32);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("addr",    32'(read_address_o), 32'(m_pc % LIMIT));
        chk("pc",      pc_o,                32'(m_pc));
        chk("pc4",     pc_plus4_o,          32'(m_pc + 4));
        chk("valid",   32'(instr_valid_o),  32'(m_mode == 1));
        chk("halted",  32'(halted_o),       32'(m_mode == 2));
        chk("trap",    32'(trap_o),         32'(m_mode == 3));
        chk("cause",   32'(trap_cause_o),   32'(m_cause));
        chk("cycles",  cycle_count_o,       32'(m_cyc));
        chk("instret", instret_o,           32'(m_inst));
    endtask

    task automatic step(input logic s, input logic r, input logic h, input logic [31:0] t);
        stall_i = s; redirect_valid_i = r; halt_i = h; redirect_target_i = t;
        @(posedge clk);
        model_step(s, r, h, t);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        stall_i = 1'b0; redirect_valid_i = 1'b0; halt_i = 1'b0; redirect_target_i = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall, redir, halt;
        logic [31:0] tgt;
        logic [31:0] addr, pc4;
        logic        valid, trap;
        logic [1:0]  cause;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h00, 32'h04, 1'b1, 1'b0, 2'd0, 32'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h04, 32'h08, 1'b1, 1'b0, 2'd0, 32'd1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h08, 32'h0C, 1'b1, 1'b0, 2'd0, 32'd2};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0C, 32'h10, 1'b1, 1'b0, 2'd0, 32'd3};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h10, 32'h14, 1'b1, 1'b0, 2'd0, 32'd4};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h10, 32'h14, 1'b1, 1'b0, 2'd0, 32'd4};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'h40, 32'h44, 1'b1, 1'b0, 2'd0, 32'd5};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h42, 32'h40, 32'h44, 1'b0, 1'b1, 2'd1, 32'd5};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'h80, 32'h40, 32'h44, 1'b0, 1'b1, 2'd1, 32'd5};

        // Directed table straight out of reset (first row is the BOOT edge).
        do_reset();
        chk("boot_addr",  32'(read_address_o), 32'h0);
        chk("boot_valid", 32'(instr_valid_o),  32'h0);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].stall, tbl[i].redir, tbl[i].halt, tbl[i].tgt);
            chk($sformatf("tbl%0d_addr", i),  32'(read_address_o), tbl[i].addr);
            chk($sformatf("tbl%0d_pc4", i),   pc_plus4_o,          tbl[i].pc4);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid_o),  32'(tbl[i].valid));
            chk($sformatf("tbl%0d_trap", i),  32'(trap_o),         32'(tbl[i].trap));
            chk($sformatf("tbl%0d_cause", i), 32'(trap_cause_o),   32'(tbl[i].cause));
            chk($sformatf("tbl%0d_inst", i),  instret_o,           tbl[i].inst);
        end

        // Redirect exactly to 2^ADDR_WIDTH.
        do_reset();
        step(0, 0, 0, 0);
        step(0, 1, 0, 32'h400);
        check_model();
        chk("oor_cause", 32'(trap_cause_o), 32'd2);
        chk("oor_pc",    pc_o,              32'h0);

        // Fall off the end of the ROM.
        do_reset();
        step(0, 0, 0, 0);
        step(0, 1, 0, 32'h3F0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("end_pc", pc_o, 32'h3FC);
        step(0, 0, 0, 0);
        check_model();
        chk("end_cause", 32'(trap_cause_o), 32'd2);
        chk("end_pc_held", pc_o, 32'h3FC);
        chk("end_inst", instret_o, 32'd4);
        chk("end_cycles", cycle_count_o, 32'd5);

        // Halt at 0x08, then further inputs are ignored.
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("halt_flag", 32'(halted_o), 32'd1);
        chk("halt_pc",   pc_o,          32'h08);
        chk("halt_inst", instret_o,     32'd3);
        step(0, 1, 0, 32'h20);
        step(0, 0, 1, 0);
        check_model();
        chk("halt_pc_frozen", pc_o, 32'h08);

        // Asynchronous reset mid-RUN while stalled, between clock edges.
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("pre_areset_pc", pc_o, 32'h0C);
        stall_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("areset_pc",    pc_o,               32'h0);
        chk("areset_valid", 32'(instr_valid_o), 32'h0);
        chk("areset_inst",  instret_o,          32'h0);
        chk("areset_cyc",   cycle_count_o,      32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0);
        chk("restart_addr0", 32'(read_address_o), 32'h0);
        step(0, 0, 0, 0);
        chk("restart_addr4", 32'(read_address_o), 32'h4);
        check_model();

        // Random episodes against the model.
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                logic        s, r, h;
                logic [31:0] t;
                int unsigned k;
                s = ($urandom_range(0, 4) == 0);
                r = ($urandom_range(0, 5) == 0);
                h = ($urandom_range(0, 60) == 0);
                k = $urandom_range(0, 9);
                if (k == 0)      t = $urandom_range(0, 1023);
                else if (k == 1) t = 32'($urandom_range(256, 1023)) << 2;
                else if (k == 2) t = $urandom;
                else             t = 32'($urandom_range(0, 255)) << 2;
                step(s, r, h, t);
                check_model();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
